// File: rtl/adt7420_pkg.sv
// adt7420_pkg: shared types and constants for the ADT7420 temperature reader
package adt7420_pkg;
  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, RD_MSB, MSB_ACK, RD_LSB, LSB_NACK, STOP
  } i2c_state_t;
  localparam logic [6:0] ADT7420_ADDR = 7'h4B;
  localparam logic I2C_READ = 1'b1;
  localparam int TEMP_W = 13;
endpackage

// File: rtl/i2c_bit_timer.sv
// i2c_bit_timer: per-slot phase counter and bit counter with slot strobes
// Ports: clk/rst_n (sync, active-low), clear restarts slot 0 bit 0;
// phase/bit_cnt give position; slot_start (p=0), drive_pt (p=HALF/2),
// sample_pt (p=HALF+HALF/2), slot_end (last phase) are single-cycle strobes.
module i2c_bit_timer #(
  parameter int HALF_PERIOD = 10,
  localparam int PW = $clog2(2 * HALF_PERIOD)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  output logic [PW-1:0] phase,
  output logic [2:0]    bit_cnt,
  output logic          slot_start,
  output logic          drive_pt,
  output logic          sample_pt,
  output logic          slot_end
);
  localparam logic [PW-1:0] LAST_P = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0] DRIVE_P = PW'(HALF_PERIOD / 2);
  localparam logic [PW-1:0] SAMPLE_P = PW'(HALF_PERIOD + HALF_PERIOD / 2);
  assign slot_start = phase == '0;
  assign drive_pt = phase == DRIVE_P;
  assign sample_pt = phase == SAMPLE_P;
  assign slot_end = phase == LAST_P;
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      phase <= '0;
      bit_cnt <= '0;
    end else begin
      phase <= slot_end ? '0 : phase + 1'b1;
      bit_cnt <= bit_cnt + {2'b00, slot_end};
    end
  end
endmodule

// File: rtl/adt7420_temp_reader.sv
// adt7420_temp_reader: I2C master reading the ADT7420 16-bit temperature register
// Ports: clk_200kHz (only clock), rst_n (sync, active-low), start (request a read,
// sampled in IDLE), sda_in (synchronised SDA level); sda_oe (1 = pull SDA low),
// scl (push-pull), busy, valid (1-cycle pulse on update), ack_error (address NACK,
// held until next accepted start), temp_data (sensor bits [15:3], 0.0625 C/LSB).
module adt7420_temp_reader
  import adt7420_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = ADT7420_ADDR,
  parameter int HALF_PERIOD = 10
) (
  input  logic              clk_200kHz,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              scl,
  output logic              busy,
  output logic              valid,
  output logic              ack_error,
  output logic [TEMP_W-1:0] temp_data
);
  localparam int PW = $clog2(2 * HALF_PERIOD);
  localparam logic [PW-1:0] SCL_RISE = PW'(HALF_PERIOD);
  localparam logic [PW-1:0] DRIVE_P = PW'(HALF_PERIOD / 2);
  localparam logic [PW-1:0] SAMPLE_P = PW'(HALF_PERIOD + HALF_PERIOD / 2);
  localparam logic [7:0] ADDR_BYTE = {DEV_ADDR, I2C_READ};
  i2c_state_t state, nextState;
  logic [PW-1:0] phase;
  logic [2:0] bitCnt;
  logic slotStart, drivePt, samplePt, slotEnd, clear, lastBit, driveBit, heldOe;
  logic [15:0] shiftReg;
  logic [2:0] unusedBits;
  assign lastBit = &bitCnt;
  assign clear = (state == IDLE) || (nextState != state);
  assign unusedBits = shiftReg[2:0];
  i2c_bit_timer #(.HALF_PERIOD(HALF_PERIOD)) timer (
    .clk(clk_200kHz),
    .rst_n(rst_n),
    .clear(clear),
    .phase(phase),
    .bit_cnt(bitCnt),
    .slot_start(slotStart),
    .drive_pt(drivePt),
    .sample_pt(samplePt),
    .slot_end(slotEnd)
  );
  always_ff @(posedge clk_200kHz) state <= !rst_n ? IDLE : nextState;
  // driveBit is the SDA pull-low level applied from the drive point of a slot;
  // START leaves it at 1 so SDA stays low into the first address bit.
  always_comb begin
    nextState = state;
    driveBit = 1'b0;
    unique case (state)
      IDLE:     nextState = start ? START : IDLE;
      START: begin
        driveBit = 1'b1;
        nextState = slotEnd ? ADDR : START;
      end
      ADDR: begin
        driveBit = ~ADDR_BYTE[~bitCnt];
        nextState = (slotEnd && lastBit) ? ADDR_ACK : ADDR;
      end
      ADDR_ACK: nextState = slotEnd ? (ack_error ? STOP : RD_MSB) : ADDR_ACK;
      RD_MSB:   nextState = (slotEnd && lastBit) ? MSB_ACK : RD_MSB;
      MSB_ACK: begin
        driveBit = 1'b1;
        nextState = slotEnd ? RD_LSB : MSB_ACK;
      end
      RD_LSB:   nextState = (slotEnd && lastBit) ? LSB_NACK : RD_LSB;
      LSB_NACK: nextState = slotEnd ? STOP : LSB_NACK;
      STOP:     nextState = slotEnd ? IDLE : STOP;
      default:  nextState = IDLE;
    endcase
    busy = state != IDLE;
    scl = (state == IDLE || state == START) ? 1'b1 : phase >= SCL_RISE;
    sda_oe = (state == IDLE) ? 1'b0 :
             (state == START) ? phase >= SCL_RISE :
             (state == STOP) ? (phase >= DRIVE_P && phase < SAMPLE_P) :
             drivePt ? driveBit : heldOe;
  end
  always_ff @(posedge clk_200kHz) begin
    if (!rst_n) begin
      heldOe <= 1'b0;
      shiftReg <= '0;
      ack_error <= 1'b0;
      valid <= 1'b0;
      temp_data <= '0;
    end else begin
      valid <= 1'b0;
      heldOe <= (state == IDLE) ? 1'b0 : drivePt ? driveBit : heldOe;
      if (state == START && slotStart)
        shiftReg <= '0;
      else if ((state == RD_MSB || state == RD_LSB) && samplePt)
        shiftReg <= {shiftReg[14:0], sda_in};
      if (state == IDLE && start)
        ack_error <= 1'b0;
      else if (state == ADDR_ACK && samplePt && sda_in)
        ack_error <= 1'b1;
      if (state == STOP && slotEnd && !ack_error) begin
        temp_data <= shiftReg[15:3];
        valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_adt7420_temp_reader.sv
// tb_adt7420_temp_reader: directed checks of the ADT7420 reader against a bus-level slave
module tb_adt7420_temp_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sda_in, sda_oe, scl, busy, valid, ack_error;
  logic [12:0] temp_data;
  int checks = 0;
  int errors = 0;
  int validCnt = 0;
  logic present = 1'b1;
  logic slaveRst = 1'b1;
  logic [15:0] slaveData = 16'h0000;
  logic slaveLow = 1'b0;
  logic prevScl = 1'b1;
  logic prevSda = 1'b1;
  logic [7:0] addrSeen = 8'h00;
  logic mAck = 1'bx;
  logic mNack = 1'bx;
  int k = 99;

  always #5 clk = ~clk;

  adt7420_temp_reader dut (
    .clk_200kHz(clk),
    .rst_n(rst_n),
    .start(start),
    .sda_in(sda_in),
    .sda_oe(sda_oe),
    .scl(scl),
    .busy(busy),
    .valid(valid),
    .ack_error(ack_error),
    .temp_data(temp_data)
  );

  assign sda_in = ~(sda_oe | slaveLow);

  always @(negedge clk) if (valid) validCnt++;

  // Slave: counts SCL rises after START, changes SDA on SCL falls.
  always @(negedge clk) begin
    logic sda;
    sda = sda_in;
    if (slaveRst) begin
      k = 99;
      slaveLow = 1'b0;
    end else if (prevScl && scl && prevSda && !sda) begin
      k = 0;
    end else if (!prevScl && scl) begin
      k = k + 1;
      if (k >= 1 && k <= 8) addrSeen = {addrSeen[6:0], sda};
      if (k == 18) mAck = sda;
      if (k == 27) mNack = sda;
    end else if (prevScl && !scl) begin
      slaveLow = (k == 8) ? present :
                 (k >= 9 && k <= 16) ? present & ~slaveData[24-k] :
                 (k >= 18 && k <= 25) ? present & ~slaveData[25-k] : 1'b0;
    end
    prevScl = scl;
    prevSda = sda_in;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    int busySeen;
    int v0;
    tick(3);
    rst_n = 1'b1;
    slaveRst = 1'b0;
    check("rst_scl", scl, 1);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_ack_error", ack_error, 0);
    check("rst_temp", temp_data, 0);
    busySeen = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (busy || sda_oe || !scl) busySeen++;
    end
    check("idle_quiet", busySeen, 0);

    // 25.0 C
    slaveData = 16'h0C80;
    accept();
    check("t1_busy_e0", busy, 1);
    tick(579);
    check("t1_valid_579", valid, 0);
    check("t1_busy_579", busy, 1);
    tick(1);
    check("t1_valid_580", valid, 1);
    check("t1_busy_580", busy, 0);
    check("t1_temp", temp_data, 16'h0190);
    check("t1_ack_error", ack_error, 0);
    check("t1_addr_byte", addrSeen, 16'h0097);
    check("t1_master_ack", mAck, 0);
    check("t1_master_nack", mNack, 1);
    tick(1);
    check("t1_valid_581", valid, 0);

    // -55 C, extra start mid-transaction, then start held high
    slaveData = 16'hE480;
    v0 = validCnt;
    accept();
    tick(299);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(279);
    check("t2_valid_579", valid, 0);
    start = 1'b1;
    tick(1);
    check("t2_valid_580", valid, 1);
    check("t2_busy_580", busy, 0);
    check("t2_temp", temp_data, 16'h1C90);
    check("t2_master_ack", mAck, 0);
    check("t2_master_nack", mNack, 1);
    tick(1);
    check("t3_busy_581", busy, 1);
    check("t3_valid_581", valid, 0);
    start = 1'b0;
    present = 1'b0;

    // Third transaction with no slave: NACK path
    tick(195);
    check("t3_ack_error_195", ack_error, 0);
    tick(1);
    check("t3_ack_error_196", ack_error, 1);
    tick(23);
    check("t3_busy_219", busy, 1);
    tick(1);
    check("t3_busy_220", busy, 0);
    check("t3_valid_220", valid, 0);
    tick(20);
    check("t3_ack_error_hold", ack_error, 1);
    check("t3_temp_hold", temp_data, 16'h1C90);
    check("t2_t3_valid_count", validCnt - v0, 1);

    // Reset mid-RD_MSB
    present = 1'b1;
    slaveData = 16'h0C80;
    accept();
    check("t4_ack_error_cleared", ack_error, 0);
    tick(249);
    rst_n = 1'b0;
    slaveRst = 1'b1;
    tick(1);
    check("t4_rst_scl", scl, 1);
    check("t4_rst_sda_oe", sda_oe, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_valid", valid, 0);
    check("t4_rst_temp", temp_data, 0);
    tick(2);
    rst_n = 1'b1;
    slaveRst = 1'b0;
    tick(5);

    v0 = validCnt;
    accept();
    tick(580);
    check("t5_valid_580", valid, 1);
    check("t5_temp", temp_data, 16'h0190);
    check("t5_ack_error", ack_error, 0);
    tick(20);
    check("t5_valid_count", validCnt - v0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adt7420_temp_reader.md
# adt7420_temp_reader

I2C master that reads the 16-bit temperature register of the ADT7420 sensor and presents the 13-bit result. It runs directly downstream of `adt7420_clock_generator`, clocked by its 200 kHz output. It derives a 10 kHz SCL internally, so it needs no second clock. The temperature value feeds the fan-control logic.

## Interface
- `DEV_ADDR`, default 7'h4B: 7-bit I2C address of the ADT7420.
- `HALF_PERIOD`, default 10: `clk_200kHz` cycles per SCL half-period; SCL period = 2×`HALF_PERIOD` (20 cycles → 10 kHz).
- `clk_200kHz` input 1: the only clock; all logic is on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: request one read transaction; sampled only in IDLE.
- `sda_in` input 1: SDA line level (already synchronised at the top level).
- `sda_oe` output 1: 1 = pull SDA low, 0 = release; open-drain.
- `scl` output 1: SCL drive, push-pull.
- `busy` output 1: high from start acceptance until the return to IDLE.
- `valid` output 1: one-cycle pulse when `temp_data` updates.
- `ack_error` output 1: address phase was NACKed; holds until the next accepted `start`.
- `temp_data` output 13: sensor bits [15:3], two's complement, 0.0625 °C/LSB.

## Operation
- Register pointer: the ADT7420 powers up with the pointer at 0x00, so the block performs only a 2-byte read and never writes the pointer.
- Transaction sequence:
  - START
  - address byte {`DEV_ADDR`, 1} (0x97 at default), MSB first; slave ACK bit
  - MSB data byte; master ACK (SDA low)
  - LSB data byte; master NACK (SDA released)
  - STOP
- FSM states: IDLE, START, ADDR, ADDR_ACK, RD_MSB, MSB_ACK, RD_LSB, LSB_NACK, STOP.
- Each state except IDLE lasts 8 or 1 bit slots; each slot lasts 20 cycles, indexed by phase counter p = 0..19.
- Data/ACK slot:
  - `scl` = 0 for p 0–9 and 1 for p 10–19.
  - `sda_oe` updates only at p = 5.
  - `sda_in` is sampled at p = 15.
- START slot:
  - `scl` = 1 for the whole slot.
  - `sda_oe` = 0 for p 0–9 and 1 for p 10–19.
- STOP slot:
  - `scl` = 0 for p 0–9 and 1 for p 10–19.
  - `sda_oe` = 1 from p 5 to p 14, then 0 from p 15.
- Bit order: MSB first on transmit and receive, shifted into a 16-bit register.
- ADDR_ACK:
  - If the sample reads 1 (NACK), set `ack_error` and go to STOP. No data states run, no `valid` is issued, and `temp_data` is unchanged.
  - If the sample reads 0, go to RD_MSB.
- End of STOP on a good transaction: `temp_data` ← shift[15:3], `valid` pulses, and the FSM returns to IDLE.
- `start` handling:
  - `start` during `busy` is ignored; no queueing.
  - `start` held high re-triggers on the first IDLE cycle.
  - Accepting `start` clears `ack_error`.
- Reset mid-transaction: on the next edge the block returns to IDLE with all outputs at reset values. The bus may be left mid-byte; recovery is the slave's timeout and the next START.

## Timing
- Reset values: `scl` 1, `sda_oe` 0, `busy` 0, `valid` 0, `ack_error` 0, `temp_data` 0.
- `start` is sampled high at edge E0. START slot is active from E0; `busy` is high from E0.
- Slot count: 1 START + 27 bit slots + 1 STOP = 29 slots, 580 cycles.
- `valid` is high for exactly the cycle after edge E0+580. `busy` falls on that same edge.
- Back-to-back: the earliest next acceptance is at edge E0+581.
- NACK path: 1 START + 9 address slots + 1 STOP = 220 cycles. `ack_error` rises at E0+196 (ADDR_ACK p = 15).
- With the 10 kHz SCL, one read takes 2.9 ms.

## Structure
- Package `adt7420_pkg` holds:
  - state enum `i2c_state_t`
  - `ADT7420_ADDR` = 7'h4B
  - `I2C_READ` = 1'b1
  - `TEMP_W` = 13
- Sub-module `i2c_bit_timer`:
  - contains the phase counter (0 .. 2×`HALF_PERIOD`−1) and the bit counter
  - outputs strobes `slot_start`, `drive_pt` (p = 5), `sample_pt` (p = 15), `slot_end`
  - has a `clear` input
- The FSM and the shift registers stay in `adt7420_temp_reader`.

## Test plan
- Reset then idle 100 cycles → `scl`=1, `sda_oe`=0, all outputs 0, `busy` never high.
- Slave model ACKs and returns 0x0C80; pulse `start` → `sda_oe` shows the 0x97 pattern, `valid` after 580 cycles, `temp_data`=13'h0190 (25.0 °C), `ack_error`=0.
- Slave returns 0xE480 (−55 °C) → `temp_data`=13'h1C90; master ACK seen on the MSB slot, NACK on the LSB slot.
- No slave (SDA pulled up) → `ack_error`=1 at cycle 196, `busy` low at cycle 220, no `valid`, `temp_data` holds its previous value.
- `start` pulsed at cycle 300 of a transaction → ignored; exactly one `valid`. Then `start` held high → a second transaction begins at cycle 581.
- `rst_n` low at cycle 250 mid-RD_MSB → next edge `scl`=1, `sda_oe`=0, `busy`=0; a later `start` completes normally.
